stream_merger: RTL and testbench

Upstream-direction counterpart of the packet router. Merges four typed 64-bit AXI-Stream sources (player, bullet, reserved, enemy) into one output stream. Arbitration is round-robin and packet-atomic. The type byte is stamped into the first beat of each packet, so the host-side or far-end router can demultiplex on `tdata[7:0]`. It sits between the game-logic blocks and the link/serializer toward the host.

---
 rtl/stream_merger_pkg.sv | 22 ++
 rtl/stream_merger_if.sv | 25 ++
 rtl/stream_merger_rr_arbiter4.sv | 27 ++
 rtl/stream_merger.sv | 159 +++++++++++++++
 tb/tb_stream_merger.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_merger_pkg.sv
// Shared stream constants for merger and router.
// Packet type codes, FSM encoding, beat bundle.
package stream_pkg;

  localparam int AXIS_DATA_W = 64;

  localparam logic [7:0] PKT_PLAYER   = 8'h01;
  localparam logic [7:0] PKT_BULLET   = 8'h02;
  localparam logic [7:0] PKT_ENEMY    = 8'h03;
  localparam logic [7:0] PKT_RESERVED = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tlast;
  } beat_t;

endpackage

// File: rtl/stream_merger_if.sv
// AXI-Stream bundle used around the merger.
// master drives data/valid/last, slave drives ready.
interface stream_merger_if;
  import stream_pkg::*;

  logic [AXIS_DATA_W-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/stream_merger_rr_arbiter4.sv
// Four-way round-robin pick, purely combinational.
// Search starts just after last_grant and wraps.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] grant_o,
  output logic       hit_o
);

  logic [1:0] idx;

  // Walk from lowest to highest priority so the
  // nearest requester after last_grant wins.
  always_comb begin
    grant_o = last_grant_i;
    hit_o   = 1'b0;
    idx     = last_grant_i;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant_i + 2'(k);
      if (req_i[idx]) begin
        grant_o = idx;
        hit_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_merger.sv
// Four-source packet-atomic round-robin merger.
// Stamps the source type into byte 0 of each packet.
module stream_merger
  import stream_pkg::*;
#(
  parameter logic [7:0] PORT0_TYPE = PKT_PLAYER,
  parameter logic [7:0] PORT1_TYPE = PKT_BULLET,
  parameter logic [7:0] PORT2_TYPE = PKT_RESERVED,
  parameter logic [7:0] PORT3_TYPE = PKT_ENEMY
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [AXIS_DATA_W-1:0] i_s_axis_port0_tdata,
  input  logic                   i_s_axis_port0_tvalid,
  input  logic                   i_s_axis_port0_tlast,
  output logic                   o_s_axis_port0_tready,
  input  logic [AXIS_DATA_W-1:0] i_s_axis_port1_tdata,
  input  logic                   i_s_axis_port1_tvalid,
  input  logic                   i_s_axis_port1_tlast,
  output logic                   o_s_axis_port1_tready,
  input  logic [AXIS_DATA_W-1:0] i_s_axis_port2_tdata,
  input  logic                   i_s_axis_port2_tvalid,
  input  logic                   i_s_axis_port2_tlast,
  output logic                   o_s_axis_port2_tready,
  input  logic [AXIS_DATA_W-1:0] i_s_axis_port3_tdata,
  input  logic                   i_s_axis_port3_tvalid,
  input  logic                   i_s_axis_port3_tlast,
  output logic                   o_s_axis_port3_tready,
  output logic [AXIS_DATA_W-1:0] o_m_axis_tdata,
  output logic                   o_m_axis_tvalid,
  output logic                   o_m_axis_tlast,
  input  logic                   i_m_axis_tready
);

  logic [AXIS_DATA_W-1:0] in_data [4];
  logic [3:0]             in_valid;
  logic [3:0]             in_last;
  logic [3:0]             tready;

  state_e                 state_q;
  logic [1:0]             grant_q;
  logic [1:0]             last_grant_q;
  logic                   first_q;
  logic [AXIS_DATA_W-1:0] out_data_q;
  logic                   out_valid_q;
  logic                   out_last_q;

  logic [1:0]             arb_grant;
  logic                   arb_hit;
  logic                   out_free;
  logic                   take;
  logic                   accept;
  logic [7:0]             type_sel;
  beat_t                  beat_d;

  assign in_data[0] = i_s_axis_port0_tdata;
  assign in_data[1] = i_s_axis_port1_tdata;
  assign in_data[2] = i_s_axis_port2_tdata;
  assign in_data[3] = i_s_axis_port3_tdata;

  assign in_valid = {i_s_axis_port3_tvalid,
                     i_s_axis_port2_tvalid,
                     i_s_axis_port1_tvalid,
                     i_s_axis_port0_tvalid};

  assign in_last  = {i_s_axis_port3_tlast,
                     i_s_axis_port2_tlast,
                     i_s_axis_port1_tlast,
                     i_s_axis_port0_tlast};

  rr_arbiter4 u_arb (
    .req_i        (in_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .hit_o        (arb_hit)
  );

  // Room in the output slot now, or it drains this edge.
  assign out_free = !out_valid_q || i_m_axis_tready;
  assign take     = (state_q == ST_BUSY) && out_free;
  assign accept   = take && in_valid[grant_q];

  // Only the granted port sees ready, and only with room.
  always_comb begin
    tready          = '0;
    tready[grant_q] = take;
  end

  assign o_s_axis_port0_tready = tready[0];
  assign o_s_axis_port1_tready = tready[1];
  assign o_s_axis_port2_tready = tready[2];
  assign o_s_axis_port3_tready = tready[3];

  // Type code of the currently granted source.
  always_comb begin
    type_sel = PORT0_TYPE;
    unique case (grant_q)
      2'd0: type_sel = PORT0_TYPE;
      2'd1: type_sel = PORT1_TYPE;
      2'd2: type_sel = PORT2_TYPE;
      2'd3: type_sel = PORT3_TYPE;
    endcase
  end

  // Next output beat: stamp byte 0 on a packet's first beat.
  always_comb begin
    beat_d.tdata = in_data[grant_q];
    beat_d.tlast = in_last[grant_q];
    if (first_q) begin
      beat_d.tdata[7:0] = type_sel;
    end
  end

  // Arbitration FSM plus the one-entry output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      first_q      <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      if (accept) begin
        out_data_q  <= beat_d.tdata;
        out_last_q  <= beat_d.tlast;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && i_m_axis_tready) begin
        out_valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (arb_hit) begin
            grant_q      <= arb_grant;
            last_grant_q <= arb_grant;
            first_q      <= 1'b1;
            state_q      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept) begin
            first_q <= 1'b0;
            if (beat_d.tlast) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_m_axis_tdata  = out_data_q;
  assign o_m_axis_tvalid = out_valid_q;
  assign o_m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_stream_merger.sv
// Scoreboard bench for stream_merger.
// Packet-level round-robin model plus output queue.
module tb_stream_merger;
  import stream_pkg::*;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } xbeat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_ready = 1'b1;
  logic        rnd_on = 1'b0;
  logic [63:0] drv_data [4];
  logic        drv_valid [4];
  logic        drv_last [4];
  logic [3:0]  rdy;

  int checks = 0;
  int errors = 0;

  xbeat_t exp_q[$];
  int     grant_log[$];
  int     mdl_last = 3;
  int     mgrant = 0;
  bit     busy = 1'b0;
  bit     first = 1'b0;
  bit     prev_acc = 1'b0;
  bit     prev_stall = 1'b0;
  xbeat_t prev_beat;
  xbeat_t prev_out;

  always #5 clk = ~clk;

  stream_merger_if s0 ();
  stream_merger_if s1 ();
  stream_merger_if s2 ();
  stream_merger_if s3 ();
  stream_merger_if m ();

  assign s0.tdata = drv_data[0];
  assign s0.tvalid = drv_valid[0];
  assign s0.tlast = drv_last[0];
  assign s1.tdata = drv_data[1];
  assign s1.tvalid = drv_valid[1];
  assign s1.tlast = drv_last[1];
  assign s2.tdata = drv_data[2];
  assign s2.tvalid = drv_valid[2];
  assign s2.tlast = drv_last[2];
  assign s3.tdata = drv_data[3];
  assign s3.tvalid = drv_valid[3];
  assign s3.tlast = drv_last[3];
  assign m.tready = m_ready;
  assign rdy = {s3.tready, s2.tready, s1.tready, s0.tready};

  stream_merger dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_s_axis_port0_tdata  (s0.tdata),
    .i_s_axis_port0_tvalid (s0.tvalid),
    .i_s_axis_port0_tlast  (s0.tlast),
    .o_s_axis_port0_tready (s0.tready),
    .i_s_axis_port1_tdata  (s1.tdata),
    .i_s_axis_port1_tvalid (s1.tvalid),
    .i_s_axis_port1_tlast  (s1.tlast),
    .o_s_axis_port1_tready (s1.tready),
    .i_s_axis_port2_tdata  (s2.tdata),
    .i_s_axis_port2_tvalid (s2.tvalid),
    .i_s_axis_port2_tlast  (s2.tlast),
    .o_s_axis_port2_tready (s2.tready),
    .i_s_axis_port3_tdata  (s3.tdata),
    .i_s_axis_port3_tvalid (s3.tvalid),
    .i_s_axis_port3_tlast  (s3.tlast),
    .o_s_axis_port3_tready (s3.tready),
    .o_m_axis_tdata        (m.tdata),
    .o_m_axis_tvalid       (m.tvalid),
    .o_m_axis_tlast        (m.tlast),
    .i_m_axis_tready       (m.tready)
  );

  function automatic logic [7:0] ptype(int p);
    case (p)
      0: return 8'h01;
      1: return 8'h02;
      2: return 8'hFF;
      default: return 8'h03;
    endcase
  endfunction

  // Round robin: first requester after the last winner.
  function automatic int rr_pick(logic [3:0] v, int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor and reference model, mid-cycle.
  always @(negedge clk) begin
    logic [3:0] vin;
    logic [3:0] acc;
    logic [3:0] exp_rdy;
    xbeat_t     b;
    xbeat_t     h;
    if (rst) begin
      mdl_last = 3;
      busy = 1'b0;
      first = 1'b0;
      prev_acc = 1'b0;
      prev_stall = 1'b0;
      exp_q.delete();
      grant_log.delete();
    end else begin
      for (int p = 0; p < 4; p++) begin
        vin[p] = drv_valid[p];
        acc[p] = drv_valid[p] && rdy[p];
        exp_rdy[p] = busy && (p == mgrant) &&
                     (!m.tvalid || m_ready);
      end
      chk("tready", 64'(rdy), 64'(exp_rdy));
      if (prev_acc) begin
        chk("lat_valid", 64'(m.tvalid), 64'd1);
        chk("lat_data", m.tdata, prev_beat.d);
        chk("lat_last", 64'(m.tlast), 64'(prev_beat.l));
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(m.tvalid), 64'd1);
        chk("hold_data", m.tdata, prev_out.d);
        chk("hold_last", 64'(m.tlast), 64'(prev_out.l));
      end
      if (m.tvalid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_extra actual=%h required=none",
                   m.tdata);
        end else begin
          h = exp_q.pop_front();
          checks--;
          chk("out_data", m.tdata, h.d);
          chk("out_last", 64'(m.tlast), 64'(h.l));
        end
      end
      prev_stall = m.tvalid && !m_ready;
      prev_out.d = m.tdata;
      prev_out.l = m.tlast;
      prev_acc = 1'b0;
      if (acc != 4'd0) begin
        for (int p = 0; p < 4; p++) begin
          if (acc[p]) begin
            b.d = drv_data[p];
            b.l = drv_last[p];
            if (first) begin
              b.d[7:0] = ptype(p);
              grant_log.push_back(p);
            end
            first = 1'b0;
            if (b.l) busy = 1'b0;
            exp_q.push_back(b);
            prev_acc = 1'b1;
            prev_beat = b;
          end
        end
      end else if (!busy && vin != 4'd0) begin
        mgrant = rr_pick(vin, mdl_last);
        mdl_last = mgrant;
        busy = 1'b1;
        first = 1'b1;
      end
    end
  end

  // Present one beat and hold it until accepted.
  task automatic drive_beat(int p, logic [63:0] d, logic l);
    int n = 0;
    drv_valid[p] = 1'b1;
    drv_data[p] = d;
    drv_last[p] = l;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[p] && n < 500);
    if (!rdy[p]) begin
      checks++;
      errors++;
      $display("FAIL timeout port%0d actual=stalled required=accept", p);
    end
    @(posedge clk);
    #1;
    drv_valid[p] = 1'b0;
  endtask

  task automatic send_pkt(int p, int n);
    for (int i = 0; i < n; i++) begin
      drive_beat(p, {$urandom, $urandom}, (i == n - 1));
    end
  endtask

  task automatic port_stream(int p, int npk);
    for (int k = 0; k < npk; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send_pkt(p, $urandom_range(1, 4));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int p = 0; p < 4; p++) drv_valid[p] = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(m.tvalid), 64'd0);
    chk("rst_data", m.tdata, 64'd0);
    chk("rst_last", 64'(m.tlast), 64'd0);
    chk("rst_ready", 64'(rdy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy || m.tvalid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      drv_valid[p] = 1'b0;
      drv_data[p] = '0;
      drv_last[p] = 1'b0;
    end
    fork
      forever begin
        @(posedge clk);
        #1;
        if (rnd_on) m_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    do_reset();

    // Single 3-beat packet on port 0.
    drive_beat(0, 64'h1122_3344_5566_AA00, 1'b0);
    drive_beat(0, 64'h0000_0000_0000_00BB, 1'b0);
    drive_beat(0, 64'h0000_0000_0000_00CC, 1'b1);
    wait_idle();

    // Port 0 and port 3 contend after reset.
    do_reset();
    fork
      send_pkt(0, 2);
      send_pkt(3, 2);
    join
    wait_idle();
    chk("contend_n", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      chk("contend_first", 64'(grant_log[0]), 64'd0);
      chk("contend_second", 64'(grant_log[1]), 64'd3);
    end

    // Fairness with single-beat packets everywhere.
    do_reset();
    fork
      send_pkt(0, 1); send_pkt(1, 1); send_pkt(2, 1); send_pkt(3, 1);
    join
    fork
      send_pkt(0, 1); send_pkt(1, 1);
    join
    wait_idle();
    chk("fair_n", 64'(grant_log.size()), 64'd6);
    if (grant_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("fair_order", 64'(grant_log[i]), 64'(i % 4));
      end
    end

    // Port 1 requests during a locked port 0 packet.
    fork
      send_pkt(0, 4);
      begin
        repeat (3) begin @(posedge clk); #1; end
        send_pkt(1, 2);
      end
    join
    wait_idle();

    // Downstream stall mid-packet.
    fork
      send_pkt(2, 6);
      begin
        repeat (3) begin @(posedge clk); #1; end
        m_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        m_ready = 1'b1;
      end
    join
    wait_idle();

    // Random traffic with random backpressure.
    rnd_on = 1'b1;
    fork
      port_stream(0, 20);
      port_stream(1, 20);
      port_stream(2, 20);
      port_stream(3, 20);
    join
    rnd_on = 1'b0;
    m_ready = 1'b1;
    wait_idle();

    // Reset while port 3 is mid-packet.
    drive_beat(3, {$urandom, $urandom}, 1'b0);
    drv_valid[3] = 1'b1;
    drv_data[3] = {$urandom, $urandom};
    drv_last[3] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drv_valid[3] = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(m.tvalid), 64'd0);
    chk("mid_rst_data", m.tdata, 64'd0);
    chk("mid_rst_last", 64'(m.tlast), 64'd0);
    chk("mid_rst_ready", 64'(rdy), 64'd0);
    @(posedge clk);
    #1;
    fork
      send_pkt(3, 1);
      send_pkt(0, 1);
    join
    wait_idle();
    chk("post_rst_n", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      chk("post_rst_first", 64'(grant_log[0]), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
